axi_master_bridge: RTL and testbench
====================================

Name: axi_master_bridge

Overview:
- Single-outstanding AXI4 initiator that converts a simple request/stream interface into AXI4 INCR read and write bursts.
- Drives the same channel set and signal naming as the team's AXI SRAM model. It sits between the core's cache/LSU request port and the memory-side AXI responder.
- Read data is forwarded beat by beat. Write data is pulled beat by beat from the requester.
- Burst termination, responses and error status are tracked internally.

Parameters:
- BUS_WIDTH, 64, address width.
- DATA_WIDTH, 64, data width; wstrb width is DATA_WIDTH/8.
- MASTER_ID, 4'h0, value driven on ar_id/aw_id/wd_id.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  BUS_WIDTH  start address, 8-byte aligned.
- req_len  in  8  beats minus 1 (AXI len encoding).
- wdata_valid  in  1  write beat available from requester.
- wdata_ready  out  1  write beat consumed.
- wdata  in  DATA_WIDTH  write beat data.
- wdata_strb  in  DATA_WIDTH/8  write beat byte strobes.
- resp_valid  out  1  read beat valid to requester.
- resp_ready  in  1  requester accepts read beat.
- resp_data  out  DATA_WIDTH  read beat data.
- resp_last  out  1  final read beat.
- done  out  1  one-cycle pulse at transaction completion.
- done_err  out  1  valid with done; 1 = nonzero resp or beat-count mismatch.
- ar_valid/ar_ready/ar_id[4]/ar_len[8]/ar_size[3]/ar_addr[BUS_WIDTH]/ar_prot[3]/ar_burst[2]/ar_lock[2]/ar_cache[4]  out (ar_ready in)  read address channel.
- aw_valid/aw_ready/aw_id[4]/aw_len[8]/aw_size[3]/aw_addr[BUS_WIDTH]/aw_prot[3]/aw_burst[2]/aw_lock[2]/aw_cache[4]  out (aw_ready in)  write address channel.
- rd_valid in 1, rd_ready out 1, rd_id in 4, rd_data in DATA_WIDTH, rd_resp in 2, rd_last in 1  read data channel.
- wd_valid out 1, wd_ready in 1, wd_id out 4, wd_data out DATA_WIDTH, wstrb out DATA_WIDTH/8, wd_last out 1  write data channel.
- wr_valid in 1, wr_ready out 1, wr_id in 4, wr_breap in 2  write response channel.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (reset).
- Reset values: state=IDLE; ar_valid, aw_valid, wd_valid, wd_last, done, done_err are 0; address and len registers are 0; beat counter is 0.
- Constant fields:
  - ar_size = aw_size = 3'b011.
  - ar_burst = aw_burst = 2'b01 (INCR).
  - prot, lock, cache are 0.
  - ids are MASTER_ID.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- IDLE:
  - req_ready=1 only in IDLE.
  - On req_valid, latch addr, len and write, and clear the error flag.
  - Go to WR_ADDR if req_write, else RD_ADDR. The valid is asserted the next cycle (1-cycle request-to-AR/AW latency).
- RD_ADDR:
  - ar_valid=1 with ar_addr/ar_len from the latched registers.
  - ar_valid is held stable until ar_ready. On handshake, go to RD_DATA with beat counter = len.
- RD_DATA is a combinational pass-through:
  - resp_valid = rd_valid.
  - rd_ready = resp_ready.
  - resp_data = rd_data.
  - resp_last = rd_last.
  - On each rd_valid & rd_ready handshake: OR (rd_resp != 0) into the error flag, and decrement the counter if it is nonzero.
  - On a handshake with rd_last, go to IDLE and pulse done for one cycle.
  - If rd_last arrives with counter != 0, or the counter was already 0 on a non-last beat, set done_err.
  - Termination always follows rd_last.
- WR_ADDR:
  - aw_valid=1, held stable until aw_ready. On handshake, go to WR_DATA with counter = len.
  - No W beat is issued before the AW handshake completes.
- WR_DATA:
  - wd_valid = wdata_valid.
  - wdata_ready = wd_ready.
  - wd_data = wdata; wstrb = wdata_strb.
  - wd_last = (counter == 0).
  - The counter decrements on each wd_valid & wd_ready handshake.
  - A handshake with wd_last goes to WR_RESP.
- WR_RESP:
  - wr_ready=1.
  - On wr_valid, OR (wr_breap != 0) into the error flag, go to IDLE and pulse done.
- Outside the owning state, every handshake output is 0: rd_ready, wr_ready, wdata_ready, resp_valid, wd_valid.
- done and done_err are registered. They are high in the first IDLE cycle after completion; a new request may be accepted in that same cycle.
- req_len=0 gives a single beat; last is asserted on the first beat.
- IDs returned on rd_id/wr_id are ignored (single outstanding).
- Reset mid-burst: the FSM returns to IDLE on the next edge, all valids/readies are 0 that cycle, and no done pulse is generated.

Test Plan:
- Read, len=3, addr 0x8000_0000:
  - ar_valid on the cycle after req accept, with ar_len=3 and ar_addr=0x8000_0000.
  - 4 beats forwarded; resp_last on beat 4.
  - done=1 and done_err=0 one cycle after the last beat.
- Write, len=1, data 0x11…/0x22…, strb 0xFF:
  - aw handshake precedes any wd_valid.
  - wd_last=1 only on beat 2.
  - wr_ready=1 in WR_RESP; done=1 after the B handshake; memory holds both words.
- Back-pressure:
  - ar_ready held 0 for 5 cycles: ar_valid and ar_addr remain stable.
  - resp_ready toggled 1/0 during the read: rd_ready tracks it and no beat is dropped or duplicated.
- Error paths:
  - rd_resp=2'b10 on beat 2 of 4: done_err=1.
  - Separately, wr_breap=2'b10: done_err=1.
  - Responder asserts rd_last on beat 2 of len=3: done_err=1 and FSM returns to IDLE.
- Reset asserted in WR_DATA after 1 of 4 beats:
  - Next cycle, state is IDLE, wd_valid=0, req_ready=1 and done=0.
  - A following read with len=0 completes normally.

Source files
------------

// File: rtl/axi_master_bridge.sv
// -----------------------------------------------------------------------------
// axi_master_bridge
//
// Single-outstanding AXI4 initiator. Turns a simple request port plus a write
// beat stream into one AXI4 INCR burst at a time, and forwards read beats back
// to the requester unchanged. Burst length is tracked with a beat counter so
// that a responder ending a read burst early or late, or any non-OKAY
// response, is reported through done_err alongside the one-cycle done pulse.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_*                      request: valid/ready, write, start addr, len
//   wdata_*                    write beat stream from requester (valid/ready)
//   resp_*                     read beat stream to requester (valid/ready)
//   done, done_err             completion pulse and its error flag
//   ar_* / aw_*                AXI read / write address channels
//   rd_*                       AXI read data channel
//   wd_*, wstrb                AXI write data channel
//   wr_*                       AXI write response channel
// -----------------------------------------------------------------------------
module axi_master_bridge #(
    parameter int         BUS_WIDTH  = 64,
    parameter int         DATA_WIDTH = 64,
    parameter logic [3:0] MASTER_ID  = 4'h0
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [BUS_WIDTH-1:0]    req_addr,
    input  logic [7:0]              req_len,

    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wdata_strb,

    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_last,

    output logic                    done,
    output logic                    done_err,

    output logic                    ar_valid,
    input  logic                    ar_ready,
    output logic [3:0]              ar_id,
    output logic [7:0]              ar_len,
    output logic [2:0]              ar_size,
    output logic [BUS_WIDTH-1:0]    ar_addr,
    output logic [2:0]              ar_prot,
    output logic [1:0]              ar_burst,
    output logic [1:0]              ar_lock,
    output logic [3:0]              ar_cache,

    output logic                    aw_valid,
    input  logic                    aw_ready,
    output logic [3:0]              aw_id,
    output logic [7:0]              aw_len,
    output logic [2:0]              aw_size,
    output logic [BUS_WIDTH-1:0]    aw_addr,
    output logic [2:0]              aw_prot,
    output logic [1:0]              aw_burst,
    output logic [1:0]              aw_lock,
    output logic [3:0]              aw_cache,

    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [3:0]              rd_id,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic [1:0]              rd_resp,
    input  logic                    rd_last,

    output logic                    wd_valid,
    input  logic                    wd_ready,
    output logic [3:0]              wd_id,
    output logic [DATA_WIDTH-1:0]   wd_data,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wd_last,

    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [3:0]              wr_id,
    input  logic [1:0]              wr_breap
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BUS_WIDTH-1:0] addr_lat;
    logic [7:0]           len_lat;
    logic [7:0]           beat_cnt;
    logic [7:0]           beat_cnt_next;
    logic                 err_flag;
    logic                 err_flag_next;
    logic                 finish;

    // Only one burst is ever in flight, so returned IDs carry no information.
    logic unused_ids;
    assign unused_ids = ^{rd_id, wr_id};

    // Fixed AXI attributes: 8-byte beats, INCR bursts, normal unprivileged access.
    assign ar_id    = MASTER_ID;
    assign ar_size  = 3'b011;
    assign ar_burst = 2'b01;
    assign ar_prot  = 3'b000;
    assign ar_lock  = 2'b00;
    assign ar_cache = 4'b0000;
    assign ar_addr  = addr_lat;
    assign ar_len   = len_lat;

    assign aw_id    = MASTER_ID;
    assign aw_size  = 3'b011;
    assign aw_burst = 2'b01;
    assign aw_prot  = 3'b000;
    assign aw_lock  = 2'b00;
    assign aw_cache = 4'b0000;
    assign aw_addr  = addr_lat;
    assign aw_len   = len_lat;

    assign wd_id    = MASTER_ID;
    assign wd_data  = wdata;
    assign wstrb    = wdata_strb;
    assign resp_data = rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr_lat <= '0;
            len_lat  <= '0;
            beat_cnt <= '0;
            err_flag <= 1'b0;
            done     <= 1'b0;
            done_err <= 1'b0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
            err_flag <= err_flag_next;
            // done_err uses the next-state error so the final beat's own
            // response is included in the reported status.
            done     <= finish;
            done_err <= finish & err_flag_next;
            if (state == IDLE && req_valid) begin
                addr_lat <= req_addr;
                len_lat  <= req_len;
            end
        end
    end

    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        err_flag_next = err_flag;
        finish        = 1'b0;
        req_ready     = 1'b0;
        ar_valid      = 1'b0;
        aw_valid      = 1'b0;
        rd_ready      = 1'b0;
        resp_valid    = 1'b0;
        resp_last     = 1'b0;
        wd_valid      = 1'b0;
        wdata_ready   = 1'b0;
        wd_last       = 1'b0;
        wr_ready      = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    err_flag_next = 1'b0;
                    state_next    = req_write ? WR_ADDR : RD_ADDR;
                end
            end

            RD_ADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) begin
                    beat_cnt_next = len_lat;
                    state_next    = RD_DATA;
                end
            end

            RD_DATA: begin
                resp_valid = rd_valid;
                rd_ready   = resp_ready;
                resp_last  = rd_last;
                if (rd_valid && resp_ready) begin
                    if (rd_resp != 2'b00) begin
                        err_flag_next = 1'b1;
                    end
                    // Counter must reach zero exactly on the beat marked last;
                    // either an early or a missing rd_last is a length error.
                    if (rd_last ? (beat_cnt != 8'd0) : (beat_cnt == 8'd0)) begin
                        err_flag_next = 1'b1;
                    end
                    if (beat_cnt != 8'd0) begin
                        beat_cnt_next = beat_cnt - 8'd1;
                    end
                    if (rd_last) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            WR_ADDR: begin
                aw_valid = 1'b1;
                if (aw_ready) begin
                    beat_cnt_next = len_lat;
                    state_next    = WR_DATA;
                end
            end

            WR_DATA: begin
                wd_valid    = wdata_valid;
                wdata_ready = wd_ready;
                wd_last     = (beat_cnt == 8'd0);
                if (wdata_valid && wd_ready) begin
                    if (beat_cnt == 8'd0) begin
                        state_next = WR_RESP;
                    end else begin
                        beat_cnt_next = beat_cnt - 8'd1;
                    end
                end
            end

            WR_RESP: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    if (wr_breap != 2'b00) begin
                        err_flag_next = 1'b1;
                    end
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_master_bridge.sv
`timescale 1ns/1ps
module tb_axi_master_bridge;

    localparam int         BW  = 64;
    localparam int         DW  = 64;
    localparam int         SW  = DW / 8;
    localparam logic [3:0] MID = 4'h5;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [BW-1:0] req_addr;
    logic [7:0]    req_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wdata_strb;
    logic          resp_valid, resp_ready, resp_last;
    logic [DW-1:0] resp_data;
    logic          done, done_err;
    logic          ar_valid, ar_ready;
    logic [3:0]    ar_id, ar_cache;
    logic [7:0]    ar_len;
    logic [2:0]    ar_size, ar_prot;
    logic [BW-1:0] ar_addr;
    logic [1:0]    ar_burst, ar_lock;
    logic          aw_valid, aw_ready;
    logic [3:0]    aw_id, aw_cache;
    logic [7:0]    aw_len;
    logic [2:0]    aw_size, aw_prot;
    logic [BW-1:0] aw_addr;
    logic [1:0]    aw_burst, aw_lock;
    logic          rd_valid, rd_ready, rd_last;
    logic [3:0]    rd_id;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;
    logic          wd_valid, wd_ready, wd_last;
    logic [3:0]    wd_id;
    logic [DW-1:0] wd_data;
    logic [SW-1:0] wstrb;
    logic          wr_valid, wr_ready;
    logic [3:0]    wr_id;
    logic [1:0]    wr_breap;

    int n_tests = 0;
    int n_fail  = 0;

    // Responder-side memory: one 64-bit word per 8-byte aligned address.
    logic [63:0] mem [logic [63:0]];

    logic [63:0] ra;
    logic [7:0]  rl;

    always #5 clk = ~clk;

    axi_master_bridge #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .MASTER_ID(MID)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wdata_strb(wdata_strb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_last(resp_last),
        .done(done), .done_err(done_err),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_len(ar_len), .ar_size(ar_size),
        .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_len(aw_len), .aw_size(aw_size),
        .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_id(rd_id), .rd_data(rd_data), .rd_resp(rd_resp),
        .rd_last(rd_last),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_id(wd_id), .wd_data(wd_data), .wstrb(wstrb),
        .wd_last(wd_last),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_id(wr_id), .wr_breap(wr_breap)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 64'hC3C3_5A5A_0F0F_9696;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] st);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        ar_ready = 1'b0; aw_ready = 1'b0;
        rd_valid = 1'b0; rd_last = 1'b0; rd_resp = 2'b00; rd_data = '0; rd_id = '0;
        resp_ready = 1'b0;
        wdata_valid = 1'b0; wdata = '0; wdata_strb = '0; wd_ready = 1'b0;
        wr_valid = 1'b0; wr_breap = 2'b00; wr_id = '0;
    endtask

    // Read burst. nbeats is how many beats the responder actually sends (with
    // rd_last on the final one); rr_mode 0 = resp_ready always 1,
    // 1 = alternating, 2 = random; rv_rand randomizes rd_valid gaps.
    task automatic run_read(input logic [63:0] addr, input logic [7:0] len, input int ar_stall,
                            input int err_beat, input int nbeats, input int rr_mode,
                            input int rv_rand);
        int  i, j, cyc;
        logic exp_err;
        exp_err = (err_beat >= 0 && err_beat < nbeats) || (nbeats != int'(len) + 1);

        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
        #1;
        check_val("rd_req_ready", 64'(req_ready), 64'd1);
        check_val("rd_ar_idle", 64'(ar_valid), 64'd0);
        next_cycle();
        req_valid = 1'b0; req_addr = '1; req_len = '1;

        // Address phase; rd_valid is held high to confirm the data path stays shut.
        for (int c = 0; c <= ar_stall; c++) begin
            ar_ready = (c == ar_stall);
            rd_valid = 1'b1; resp_ready = 1'b1;
            #1;
            check_val("ar_valid", 64'(ar_valid), 64'd1);
            check_val("ar_addr", ar_addr, addr);
            check_val("rd_gate_addr", 64'({resp_valid, rd_ready}), 64'd0);
            if (c == 0) begin
                check_val("ar_len", 64'(ar_len), 64'(len));
                check_val("ar_fixed", 64'({ar_id, ar_size, ar_burst, ar_prot, ar_lock, ar_cache}),
                          64'({MID, 3'b011, 2'b01, 3'b000, 2'b00, 4'b0000}));
            end
            next_cycle();
        end
        ar_ready = 1'b0;

        i = 0; j = 0; cyc = 0;
        while (i < nbeats && cyc < 400) begin
            rd_valid   = (rv_rand == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            resp_ready = (rr_mode == 0) ? 1'b1 :
                         (rr_mode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 1) == 1);
            rd_data = mem_rd(addr + 64'(8 * i));
            rd_last = (i == nbeats - 1);
            rd_resp = (i == err_beat) ? 2'b10 : 2'b00;
            rd_id   = 4'($urandom);
            #1;
            check_val("rd_ready", 64'(rd_ready), 64'(resp_ready));
            check_val("resp_valid", 64'(resp_valid), 64'(rd_valid));
            check_val("done_busy", 64'(done), 64'd0);
            if (resp_valid && resp_ready) begin
                check_val("resp_data", resp_data, mem_rd(addr + 64'(8 * j)));
                check_val("resp_last", 64'(resp_last), 64'(j == nbeats - 1));
                j++;
            end
            if (rd_valid && rd_ready) i++;
            next_cycle();
            cyc++;
        end
        check_val("rd_beats", 64'(j), 64'(nbeats));
        rd_valid = 1'b0; rd_last = 1'b0; rd_resp = 2'b00; resp_ready = 1'b0;
        #1;
        check_val("rd_done", 64'(done), 64'd1);
        check_val("rd_done_err", 64'(done_err), 64'(exp_err));
        check_val("rd_idle_after", 64'(req_ready), 64'd1);
        next_cycle();
        #1;
        check_val("rd_done_pulse", 64'(done), 64'd0);
        next_cycle();
    endtask

    // Write burst. fixed_data gives beat k the pattern {16{k+1}} with full strobes.
    task automatic run_write(input logic [63:0] addr, input logic [7:0] len, input int aw_stall,
                             input logic [1:0] bresp, input int b_delay, input int fixed_data,
                             input int rand_bp);
        logic [63:0] wdat [256];
        logic [7:0]  wst  [256];
        logic [63:0] expw [256];
        logic [63:0] wbase;
        int i, wb, cyc;

        for (int k = 0; k <= int'(len); k++) begin
            wdat[k] = (fixed_data != 0) ? {16{4'(k + 1)}} : {$urandom, $urandom};
            wst[k]  = (fixed_data != 0) ? 8'hFF : 8'($urandom);
            expw[k] = merge(mem_rd(addr + 64'(8 * k)), wdat[k], wst[k]);
        end
        wbase = '0;

        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len;
        #1;
        check_val("wr_req_ready", 64'(req_ready), 64'd1);
        next_cycle();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '1; req_len = '1;

        for (int c = 0; c <= aw_stall; c++) begin
            aw_ready = (c == aw_stall);
            wdata_valid = 1'b1; wdata = wdat[0]; wdata_strb = wst[0]; wd_ready = 1'b1;
            #1;
            check_val("aw_valid", 64'(aw_valid), 64'd1);
            check_val("aw_addr", aw_addr, addr);
            check_val("w_before_aw", 64'({wd_valid, wdata_ready}), 64'd0);
            if (c == 0) begin
                check_val("aw_len", 64'(aw_len), 64'(len));
                check_val("aw_fixed", 64'({aw_id, aw_size, aw_burst, aw_prot, aw_lock, aw_cache}),
                          64'({MID, 3'b011, 2'b01, 3'b000, 2'b00, 4'b0000}));
            end
            if (aw_valid && aw_ready) wbase = aw_addr;
            next_cycle();
        end
        aw_ready = 1'b0;

        i = 0; wb = 0; cyc = 0;
        while (i <= int'(len) && cyc < 400) begin
            wdata_valid = (rand_bp != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            wd_ready    = (rand_bp != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
            wdata = wdat[i]; wdata_strb = wst[i];
            #1;
            check_val("wd_valid", 64'(wd_valid), 64'(wdata_valid));
            check_val("wdata_ready", 64'(wdata_ready), 64'(wd_ready));
            if (wd_valid && wd_ready) begin
                check_val("wd_last", 64'(wd_last), 64'(wb == int'(len)));
                check_val("wd_id", 64'(wd_id), 64'(MID));
                mem[wbase + 64'(8 * wb)] = merge(mem_rd(wbase + 64'(8 * wb)), wd_data, wstrb);
                wb++;
            end
            if (wdata_valid && wdata_ready) i++;
            next_cycle();
            cyc++;
        end
        check_val("wr_beats", 64'(i), 64'(int'(len) + 1));

        // Response phase; a pending requester beat must not leak onto W.
        for (int c = 0; c <= b_delay; c++) begin
            wdata_valid = 1'b1; wd_ready = 1'b1;
            wr_valid = (c == b_delay); wr_breap = bresp; wr_id = 4'($urandom);
            #1;
            check_val("wr_ready", 64'(wr_ready), 64'd1);
            check_val("wr_resp_gate", 64'({wd_valid, wdata_ready}), 64'd0);
            check_val("wr_done_busy", 64'(done), 64'd0);
            next_cycle();
        end
        wr_valid = 1'b0; wr_breap = 2'b00; wdata_valid = 1'b0; wd_ready = 1'b0;
        #1;
        check_val("wr_done", 64'(done), 64'd1);
        check_val("wr_done_err", 64'(done_err), 64'(bresp != 2'b00));
        check_val("wr_idle_after", 64'(req_ready), 64'd1);
        for (int k = 0; k <= int'(len); k++) begin
            check_val("wr_mem", mem_rd(addr + 64'(8 * k)), expw[k]);
        end
        next_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        rd_valid = 1'b1; resp_ready = 1'b1; wdata_valid = 1'b1; wd_ready = 1'b1; wr_valid = 1'b1;
        repeat (2) next_cycle();
        #1;
        check_val("rst_req_ready", 64'(req_ready), 64'd1);
        check_val("rst_valids", 64'({ar_valid, aw_valid, wd_valid, wd_last, resp_valid}), 64'd0);
        check_val("rst_readies", 64'({rd_ready, wr_ready, wdata_ready}), 64'd0);
        check_val("rst_done", 64'({done, done_err}), 64'd0);
        check_val("rst_addr_len", 64'({ar_addr[15:0], ar_len, aw_len}), 64'd0);
        idle_inputs();
        reset = 1'b0;
        next_cycle();

        // Directed scenarios.
        run_read(64'h0000_0000_8000_0000, 8'd3, 0, -1, 4, 0, 0);
        run_write(64'h0000_0000_0000_4000, 8'd1, 0, 2'b00, 0, 1, 0);
        run_read(64'h0000_0000_0000_4000, 8'd1, 0, -1, 2, 0, 0);
        run_read(64'h0000_0000_8000_0100, 8'd3, 5, -1, 4, 1, 0);
        run_read(64'h0000_0000_0000_0100, 8'd3, 0, 1, 4, 0, 0);
        run_write(64'h0000_0000_0000_0200, 8'd2, 1, 2'b10, 2, 0, 1);
        run_read(64'h0000_0000_0000_0300, 8'd3, 0, -1, 2, 0, 0);
        run_read(64'h0000_0000_0000_0400, 8'd0, 0, -1, 2, 0, 0);
        run_read(64'h0000_0000_0000_0500, 8'd0, 0, -1, 1, 0, 0);

        // Reset in the middle of a 4-beat write, after one beat.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h9000; req_len = 8'd3;
        next_cycle();
        req_valid = 1'b0; req_write = 1'b0; aw_ready = 1'b1;
        next_cycle();
        aw_ready = 1'b0; wdata_valid = 1'b1; wd_ready = 1'b1; wdata = 64'hDEAD_BEEF; wdata_strb = 8'hFF;
        #1;
        check_val("mid_wd_valid", 64'(wd_valid), 64'd1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        #1;
        check_val("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check_val("mid_rst_wd_valid", 64'({wd_valid, wdata_ready, aw_valid}), 64'd0);
        check_val("mid_rst_done", 64'(done), 64'd0);
        idle_inputs();
        reset = 1'b0;
        next_cycle();
        #1;
        check_val("post_rst_done", 64'(done), 64'd0);
        next_cycle();
        run_read(64'h0000_0000_0000_0600, 8'd0, 0, -1, 1, 0, 0);

        // Randomized mixed traffic over a small window so reads see earlier writes.
        for (int t = 0; t < 30; t++) begin
            ra = 64'h1000 + 64'(8 * $urandom_range(0, 63));
            rl = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                run_write(ra, rl, int'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00,
                          int'($urandom_range(0, 3)), 0, 1);
            end else begin
                run_read(ra, rl, int'($urandom_range(0, 3)),
                         ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(rl))) : -1,
                         int'(rl) + 1, 2, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
